axis_frame_limiter: RTL and testbench
=====================================

Name: axis_frame_limiter

Overview:
- AXI-Stream stage placed directly downstream of the async AXIS FIFO read port, in the FIFO's read-clock domain.
- Counts bytes per frame and enforces a maximum frame length. An oversize frame is cut at beat granularity with a forced tlast, and its remainder is discarded.
- Has a single registered output stage and emits per-frame length/truncation status plus running frame counters.

Parameters:
DATA_WIDTH, 64, tdata width in bits (multiple of 8)
KEEP_WIDTH, DATA_WIDTH/8, tkeep width
MAX_BYTES, 1518, maximum forwarded frame length in bytes; must be < 2^LEN_WIDTH
LEN_WIDTH, 16, width of length accumulator and stat_len

Ports:
axis_aclk  in  1  sole clock
axis_aresetn  in  1  asynchronous, active-low reset
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  DATA_WIDTH  input data
s_axis_tkeep  in  KEEP_WIDTH  input byte enables
s_axis_tlast  in  1  input end of frame
m_axis_tvalid  out  1  output beat valid (registered)
m_axis_tready  in  1  output ready
m_axis_tdata  out  DATA_WIDTH  output data (registered)
m_axis_tkeep  out  KEEP_WIDTH  output byte enables (registered)
m_axis_tlast  out  1  output end of frame (registered, may be forced)
stat_valid  out  1  one-cycle pulse: frame result available
stat_len  out  LEN_WIDTH  bytes forwarded for the reported frame
stat_trunc  out  1  reported frame was truncated
frame_cnt  out  32  frames terminated on the output (wraps)
trunc_cnt  out  32  frames truncated (wraps)

Behaviour:
- Reset (axis_aresetn low, asynchronous):
  - m_axis_tvalid=0; m_axis_tdata, m_axis_tkeep, m_axis_tlast=0.
  - stat_valid=0, stat_len=0, stat_trunc=0, frame_cnt=0, trunc_cnt=0.
  - Length accumulator=0; state=PASS.
  - Reset mid-frame abandons the frame. The first beat accepted after release is a frame start.
- Input accept: a beat is accepted when s_axis_tvalid && s_axis_tready.
- Output register:
  - s_axis_tready = (state==DROP) || !m_axis_tvalid || m_axis_tready.
  - Latency is 1 cycle from input accept to m_axis_tvalid.
  - The output holds data/keep/last stable while m_axis_tvalid && !m_axis_tready.
  - m_axis_tvalid clears when the beat is consumed and no new beat loads in the same cycle.
  - Full throughput: 1 beat/cycle when m_axis_tready=1.
- Byte count: beat_bytes = popcount(s_axis_tkeep); sum = acc + beat_bytes.
- State PASS, accepted beat:
  - Beat is loaded into the output register.
  - If s_axis_tlast:
    - forward with tlast=1; stat_valid=1, stat_len=sum, stat_trunc=0; frame_cnt+1; acc=0.
    - Applies even when sum >= MAX_BYTES.
  - Else if sum >= MAX_BYTES:
    - forward with m_axis_tlast forced 1; stat_valid=1, stat_len=sum, stat_trunc=1; frame_cnt+1, trunc_cnt+1; acc=0; go to DROP.
    - The forwarded frame may exceed MAX_BYTES by up to KEEP_WIDTH-1 bytes.
  - Else: forward with tlast=0; acc=sum.
- State DROP:
  - s_axis_tready=1; accepted beats are discarded, nothing is loaded, no stat.
  - Accepted beat with s_axis_tlast: go to PASS.
  - The output register still drains a pending beat independently.
- Stat outputs are registered in the same cycle the output register loads the terminating beat. stat_valid deasserts the following cycle unless another frame terminates.
- Arithmetic: sum is computed at LEN_WIDTH+1 bits; stat_len saturates at 2^LEN_WIDTH-1.
- Counters are 32-bit and wrap modulo 2^32.
- Zero-keep beats count 0 bytes and are forwarded unchanged.

Test Plan:
- Normal frame (DATA_WIDTH=64, MAX_BYTES=64): 3 beats, tkeep FF,FF,0F, tlast on beat 3, m_axis_tready=1.
  - Required: output identical, 1 cycle delay; stat_valid pulse with stat_len=20, stat_trunc=0; frame_cnt=1.
- Oversize frame: 10 full beats, tlast on beat 10.
  - Required: beats 1-8 output, beat 8 with m_axis_tlast=1; stat_len=64, stat_trunc=1, trunc_cnt=1.
  - Required: beats 9-10 accepted with s_axis_tready=1, none output.
  - Required: the next 1-beat frame is forwarded normally, frame_cnt=2.
- Exact limit: 8 full beats with tlast on beat 8.
  - Required: stat_len=64, stat_trunc=0, trunc_cnt unchanged, no DROP (beat 9 of the next frame is forwarded).
- Backpressure: m_axis_tready pattern 1,0,1,0 over a 6-beat frame.
  - Required: no lost or duplicated beats; outputs stable while stalled; s_axis_tready=0 whenever m_axis_tvalid=1 && m_axis_tready=0 in PASS.
- Back-to-back single-beat frames (tlast every cycle, tkeep=FF) for 5 cycles.
  - Required: stat_valid high 5 consecutive cycles, each stat_len=8; frame_cnt=5.
- Reset mid-frame: assert axis_aresetn=0 after beat 4 of 6.
  - Required: m_axis_tvalid=0 and counters=0 immediately (before the next edge).
  - Required: after release, a 2-beat frame (tkeep FF,FF, tlast on beat 2) reports stat_len=16.

Source files
------------

// File: rtl/axis_frame_limiter.sv
// rtl/axis_frame_limiter.sv - AXI-Stream frame length limiter with one registered output stage
// Oversize frames are cut with a forced tlast; the rest of the frame is discarded.
module axis_frame_limiter #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int MAX_BYTES  = 1518,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  axis_aclk,
   input  logic                  axis_aresetn,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tlast,
   output logic                  stat_valid,
   output logic [LEN_WIDTH-1:0]  stat_len,
   output logic                  stat_trunc,
   output logic [31:0]           frame_cnt,
   output logic [31:0]           trunc_cnt
);

   typedef enum logic {ST_PASS, ST_DROP} state_t;

   state_t                r_state;
   logic [LEN_WIDTH-1:0]  r_acc;
   logic                  r_m_tvalid;
   logic [DATA_WIDTH-1:0] r_m_tdata;
   logic [KEEP_WIDTH-1:0] r_m_tkeep;
   logic                  r_m_tlast;
   logic                  r_stat_valid;
   logic [LEN_WIDTH-1:0]  r_stat_len;
   logic                  r_stat_trunc;
   logic [31:0]           r_frame_cnt;
   logic [31:0]           r_trunc_cnt;

   logic [LEN_WIDTH:0]    w_beat_bytes;
   logic [LEN_WIDTH:0]    w_sum;
   logic [LEN_WIDTH-1:0]  w_stat_len;
   logic                  w_over;
   logic                  w_accept;
   logic                  w_load;

   always_comb begin
      w_beat_bytes = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         w_beat_bytes = w_beat_bytes + (LEN_WIDTH+1)'(s_axis_tkeep[i]);
      end
   end

   assign w_sum         = {1'b0, r_acc} + w_beat_bytes;
   assign w_over        = (w_sum >= (LEN_WIDTH+1)'(MAX_BYTES));
   assign w_stat_len    = w_sum[LEN_WIDTH] ? '1 : w_sum[LEN_WIDTH-1:0];
   // DROP never loads the output register, so it can always sink input
   assign s_axis_tready = (r_state == ST_DROP) || !r_m_tvalid || m_axis_tready;
   assign w_accept      = s_axis_tvalid && s_axis_tready;
   assign w_load        = w_accept && (r_state == ST_PASS);

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         r_state      <= ST_PASS;
         r_acc        <= '0;
         r_m_tvalid   <= 1'b0;
         r_m_tdata    <= '0;
         r_m_tkeep    <= '0;
         r_m_tlast    <= 1'b0;
         r_stat_valid <= 1'b0;
         r_stat_len   <= '0;
         r_stat_trunc <= 1'b0;
         r_frame_cnt  <= '0;
         r_trunc_cnt  <= '0;
      end else begin
         r_stat_valid <= 1'b0;
         if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tdata  <= s_axis_tdata;
            r_m_tkeep  <= s_axis_tkeep;
            r_m_tlast  <= s_axis_tlast || w_over;
         end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
         end
         if (w_accept) begin
            if (r_state == ST_DROP) begin
               if (s_axis_tlast) r_state <= ST_PASS;
            end else if (s_axis_tlast || w_over) begin
               r_stat_valid <= 1'b1;
               r_stat_len   <= w_stat_len;
               r_stat_trunc <= !s_axis_tlast;
               r_frame_cnt  <= r_frame_cnt + 32'd1;
               r_acc        <= '0;
               if (!s_axis_tlast) begin
                  r_trunc_cnt <= r_trunc_cnt + 32'd1;
                  r_state     <= ST_DROP;
               end
            end else begin
               r_acc <= w_sum[LEN_WIDTH-1:0];
            end
         end
      end
   end

   assign m_axis_tvalid = r_m_tvalid;
   assign m_axis_tdata  = r_m_tdata;
   assign m_axis_tkeep  = r_m_tkeep;
   assign m_axis_tlast  = r_m_tlast;
   assign stat_valid    = r_stat_valid;
   assign stat_len      = r_stat_len;
   assign stat_trunc    = r_stat_trunc;
   assign frame_cnt     = r_frame_cnt;
   assign trunc_cnt     = r_trunc_cnt;

endmodule

// File: tb/tb_axis_frame_limiter.sv
// tb/tb_axis_frame_limiter.sv - self-checking bench for axis_frame_limiter
// Frame-level reference model predicts forwarded beats, per-frame status and counters.
module tb_axis_frame_limiter;

   localparam int DW   = 64;
   localparam int KW   = 8;
   localparam int MAXB = 64;
   localparam int LW   = 16;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   typedef struct packed {
      logic [LW-1:0] len;
      logic          tr;
   } stat_t;

   logic          clk;
   logic          rst_n;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          s_tlast;
   logic          m_tvalid;
   logic          m_tready;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          m_tlast;
   logic          st_valid;
   logic [LW-1:0] st_len;
   logic          st_trunc;
   logic [31:0]   frame_cnt;
   logic [31:0]   trunc_cnt;

   beat_t         exp_q[$];
   stat_t         stat_q[$];
   logic [KW-1:0] fk[$];
   int            n_pass = 0;
   int            n_total = 0;
   int            mdl_frames = 0;
   int            mdl_truncs = 0;
   int            rdy_mode = 0;
   int            rdy_phase = 0;
   int            stat_run = 0;
   int            max_run = 0;
   bit            mon_en = 0;
   bit            chk_rdy = 0;
   bit            chk_lat = 0;
   bit            hold = 0;
   beat_t         held;
   beat_t         e_b;
   stat_t         e_s;

   axis_frame_limiter #(
      .DATA_WIDTH(DW),
      .KEEP_WIDTH(KW),
      .MAX_BYTES (MAXB),
      .LEN_WIDTH (LW)
   ) dut (
      .axis_aclk    (clk),
      .axis_aresetn (rst_n),
      .s_axis_tvalid(s_tvalid),
      .s_axis_tready(s_tready),
      .s_axis_tdata (s_tdata),
      .s_axis_tkeep (s_tkeep),
      .s_axis_tlast (s_tlast),
      .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready),
      .m_axis_tdata (m_tdata),
      .m_axis_tkeep (m_tkeep),
      .m_axis_tlast (m_tlast),
      .stat_valid   (st_valid),
      .stat_len     (st_len),
      .stat_trunc   (st_trunc),
      .frame_cnt    (frame_cnt),
      .trunc_cnt    (trunc_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Advance to just after the next rising edge and update the sink's ready.
   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0:       m_tready = 1'b1;
         1:       m_tready = ($urandom_range(0, 2) != 0);
         default: m_tready = (rdy_phase % 2 == 0);
      endcase
      rdy_phase++;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = l;
      for (int w = 0; ; w++) begin
         @(negedge clk);
         if (s_tready) break;
         if (w > 1000) begin
            n_total++;
            $display("FAIL send_timeout observed=stalled expected=accept");
            $fatal(1, "input never accepted");
         end
         tick();
      end
      tick();
      if (chk_lat) begin
         check("lat_valid", m_tvalid, 1'b1);
         check("lat_beat", {m_tdata, m_tkeep, m_tlast}, {d, k, l});
      end
   endtask

   // Reference: forward beats until tlast or until the running byte total reaches the limit.
   task automatic send_frame();
      logic [DW-1:0] fd[$];
      int bytes;
      bit last;
      fd = {};
      bytes = 0;
      for (int i = 0; i < fk.size(); i++) fd.push_back({$urandom, $urandom});
      for (int i = 0; i < fk.size(); i++) begin
         last = (i == fk.size() - 1);
         bytes += $countones(fk[i]);
         if (last || bytes >= MAXB) begin
            exp_q.push_back({fd[i], fk[i], 1'b1});
            stat_q.push_back({LW'(bytes), !last});
            mdl_frames++;
            if (!last) mdl_truncs++;
            break;
         end
         exp_q.push_back({fd[i], fk[i], 1'b0});
      end
      for (int i = 0; i < fk.size(); i++) send_beat(fd[i], fk[i], i == fk.size() - 1);
   endtask

   task automatic full_frame(input int n);
      fk = {};
      for (int i = 0; i < n; i++) fk.push_back(8'hFF);
   endtask

   task automatic drain();
      s_tvalid = 1'b0;
      rdy_mode = 0;
      for (int i = 0; i < 300 && (exp_q.size() != 0 || stat_q.size() != 0); i++) tick();
      tick();
      check("drain_beats", exp_q.size(), 0);
      check("drain_stats", stat_q.size(), 0);
      check("frame_cnt", frame_cnt, mdl_frames);
      check("trunc_cnt", trunc_cnt, mdl_truncs);
   endtask

   always @(negedge clk) begin
      if (!mon_en) begin
         hold     = 0;
         stat_run = 0;
      end else begin
         if (hold) begin
            check("hold_valid", m_tvalid, 1'b1);
            check("hold_beat", {m_tdata, m_tkeep, m_tlast}, held);
         end
         if (chk_rdy && m_tvalid && !m_tready) check("stall_ready", s_tready, 1'b0);
         if (m_tvalid && m_tready) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               e_b = exp_q.pop_front();
               check("out_beat", {m_tdata, m_tkeep, m_tlast}, e_b);
            end
         end
         hold = m_tvalid && !m_tready;
         held = {m_tdata, m_tkeep, m_tlast};
         if (st_valid) begin
            stat_run++;
            if (stat_run > max_run) max_run = stat_run;
            check("stat_expected", stat_q.size() != 0, 1'b1);
            if (stat_q.size() != 0) begin
               e_s = stat_q.pop_front();
               check("stat_len", st_len, e_s.len);
               check("stat_trunc", st_trunc, e_s.tr);
            end
         end else begin
            stat_run = 0;
         end
      end
   end

   initial begin
      rst_n    = 1'b0;
      s_tvalid = 1'b0;
      s_tdata  = '0;
      s_tkeep  = '0;
      s_tlast  = 1'b0;
      m_tready = 1'b1;
      repeat (3) tick();
      check("rst_m_tvalid", m_tvalid, 1'b0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tkeep", m_tkeep, 0);
      check("rst_m_tlast", m_tlast, 1'b0);
      check("rst_stat_valid", st_valid, 1'b0);
      check("rst_stat_len", st_len, 0);
      check("rst_stat_trunc", st_trunc, 1'b0);
      check("rst_frame_cnt", frame_cnt, 0);
      check("rst_trunc_cnt", trunc_cnt, 0);
      check("rst_s_tready", s_tready, 1'b1);
      rst_n  = 1'b1;
      mon_en = 1;
      tick();

      // normal frame, 20 bytes, with one-cycle latency checks
      chk_lat = 1;
      fk = {8'hFF, 8'hFF, 8'h0F};
      send_frame();
      chk_lat = 0;
      drain();

      // oversize frame cut at beat 8, followed by a normal single beat
      full_frame(10);
      send_frame();
      full_frame(1);
      send_frame();
      drain();

      // exactly at the limit, then a frame that must not be dropped
      full_frame(8);
      send_frame();
      full_frame(2);
      send_frame();
      drain();

      // alternating backpressure
      rdy_mode  = 2;
      rdy_phase = 0;
      m_tready  = 1'b1;
      chk_rdy   = 1;
      full_frame(6);
      send_frame();
      drain();
      chk_rdy = 0;

      // back-to-back single-beat frames
      max_run = 0;
      for (int i = 0; i < 5; i++) begin
         full_frame(1);
         send_frame();
      end
      drain();
      check("b2b_stat_run", max_run, 5);

      // randomized frames, keeps and sink readiness
      rdy_mode = 1;
      for (int f = 0; f < 25; f++) begin
         fk = {};
         for (int i = 0, n = $urandom_range(1, 12); i < n; i++)
            fk.push_back(($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF);
         rdy_mode = 1;
         send_frame();
      end
      drain();

      // reset in the middle of a frame
      mon_en = 0;
      for (int i = 0; i < 4; i++) send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
      s_tvalid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_m_tvalid", m_tvalid, 1'b0);
      check("midrst_frame_cnt", frame_cnt, 0);
      check("midrst_trunc_cnt", trunc_cnt, 0);
      check("midrst_stat_valid", st_valid, 1'b0);
      exp_q      = {};
      stat_q     = {};
      mdl_frames = 0;
      mdl_truncs = 0;
      tick();
      rst_n  = 1'b1;
      mon_en = 1;
      tick();
      full_frame(2);
      send_frame();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
